// File: rtl/token_pkg.sv
// token_pkg: shared run-length word type, default width and saturating increment
package token_pkg;
  localparam int LEN_W_DEFAULT = 8;
  typedef logic [LEN_W_DEFAULT-1:0] run_len_t;
  function automatic run_len_t sat_inc(run_len_t v);
    return &v ? v : v + run_len_t'(1);
  endfunction
endpackage

// File: rtl/token_len_fifo.sv
// token_len_fifo: flop FIFO (clk, rst, push/din in, pop in, full/empty/head out; head is zero when empty)
module token_len_fifo import token_pkg::*; #(
  parameter int WIDTH = LEN_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic wr, rd;
  assign full  = occ_q == OW'(DEPTH);
  assign empty = occ_q == '0;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign head  = empty ? '0 : mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wr_q] = din;
    wr_d  = wr ? wr_q + AW'(1) : wr_q;
    rd_d  = rd ? rd_q + AW'(1) : rd_q;
    occ_d = occ_q + OW'(wr) - OW'(rd);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/token_run_lengths.sv
// token_run_lengths: measures runs of 1s on a, queues lengths on len/len_valid/len_ready, sticky overflow and odd_run flags
module token_run_lengths import token_pkg::*; #(
  parameter int LEN_W      = LEN_W_DEFAULT,
  parameter int DEPTH      = 4,
  parameter bit CHECK_EVEN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic [LEN_W-1:0] len,
  output logic             len_valid,
  input  logic             len_ready,
  output logic             overflow,
  output logic             odd_run
);
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, odd_q, odd_d;
  logic full, empty, run_end, pop;
  assign run_end   = !a && |cnt_q;
  assign len_valid = !empty;
  assign pop       = len_valid && len_ready;
  assign overflow  = ovf_q;
  assign odd_run   = odd_q;
  always_comb begin
    cnt_d = a ? (&cnt_q ? cnt_q : cnt_q + LEN_W'(1)) : '0;
    ovf_d = ovf_q || (run_end && full && !pop);
    odd_d = odd_q || (CHECK_EVEN && run_end && cnt_q[0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      odd_q <= odd_d;
    end
  end
  token_len_fifo #(.WIDTH(LEN_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(run_end), .pop(pop), .din(cnt_q),
    .full(full), .empty(empty), .head(len)
  );
endmodule

// File: tb/tb_token_run_lengths.sv
// tb_token_run_lengths: table vectors plus scoreboard model against token_run_lengths
module tb_token_run_lengths;
  logic clk = 1'b0, rst = 1'b1, a = 1'b0, len_ready = 1'b0;
  logic [7:0] len;
  logic len_valid, overflow, odd_run;
  logic [3:0] len_s;
  logic len_valid_s, overflow_s, odd_run_s;
  logic [7:0] len_n;
  logic len_valid_n, overflow_n, odd_run_n;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  token_run_lengths #(.LEN_W(8), .DEPTH(4), .CHECK_EVEN(1'b1)) dut (
    .clk(clk), .rst(rst), .a(a), .len(len), .len_valid(len_valid),
    .len_ready(len_ready), .overflow(overflow), .odd_run(odd_run));
  token_run_lengths #(.LEN_W(4), .DEPTH(4), .CHECK_EVEN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .a(a), .len(len_s), .len_valid(len_valid_s),
    .len_ready(len_ready), .overflow(overflow_s), .odd_run(odd_run_s));
  token_run_lengths #(.LEN_W(8), .DEPTH(4), .CHECK_EVEN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .a(a), .len(len_n), .len_valid(len_valid_n),
    .len_ready(len_ready), .overflow(overflow_n), .odd_run(odd_run_n));
  int cnt_m, occ_m;
  bit ovf_m, odd_m;
  int q[$];
  int got[$];
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic do_reset(input logic ai);
    rst = 1'b1; a = ai; len_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; a = 1'b0;
    cnt_m = 0; occ_m = 0; ovf_m = 0; odd_m = 0;
    q.delete(); got.delete();
    chk("rst_valid", int'(len_valid), 0);
    chk("rst_len", int'(len), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_odd", int'(odd_run), 0);
  endtask
  task automatic cyc(input logic ai, input logic ri);
    bit pop_m, acc;
    a = ai; len_ready = ri;
    chk("valid", int'(len_valid), int'(occ_m != 0));
    chk("len", int'(len), occ_m != 0 ? q[0] : 0);
    chk("overflow", int'(overflow), int'(ovf_m));
    chk("odd_run", int'(odd_run), int'(odd_m));
    pop_m = occ_m != 0 && ri;
    acc = 0;
    if (pop_m) got.push_back(q.pop_front());
    if (!ai && cnt_m != 0) begin
      if (cnt_m % 2 == 1) odd_m = 1;
      if (occ_m < 4 || pop_m) begin
        q.push_back(cnt_m);
        acc = 1;
      end else ovf_m = 1;
    end
    cnt_m = ai ? (cnt_m == 255 ? 255 : cnt_m + 1) : 0;
    occ_m = occ_m + int'(acc) - int'(pop_m);
    @(negedge clk);
  endtask
  task automatic run_str(input string s, input logic ri);
    for (int i = 0; i < s.len(); i++) cyc(s[i] == "1", ri);
  endtask
  task automatic drain();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
  endtask
  typedef struct packed {
    logic        r;
    logic        ovf;
    logic        odd;
    logic [2:0]  nw;
    logic [39:0] w;
  } tv_t;
  tv_t tv [5];
  string pat [5];
  initial begin
    pat[0] = "11011011110111111001111110";
    tv[0]  = '{1'b1, 1'b0, 1'b0, 3'd5, {8'd6, 8'd6, 8'd4, 8'd2, 8'd2}};
    pat[1] = "11011011110111111001111110";
    tv[1]  = '{1'b0, 1'b1, 1'b0, 3'd4, {8'd0, 8'd6, 8'd4, 8'd2, 8'd2}};
    pat[2] = "1110110";
    tv[2]  = '{1'b1, 1'b0, 1'b1, 3'd2, {24'd0, 8'd2, 8'd3}};
    pat[3] = "10";
    tv[3]  = '{1'b1, 1'b0, 1'b1, 3'd1, {32'd0, 8'd1}};
    pat[4] = "111100";
    tv[4]  = '{1'b0, 1'b0, 1'b0, 3'd1, {32'd0, 8'd4}};
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      do_reset(1'b0);
      run_str(pat[t], tv[t].r);
      drain();
      chk($sformatf("v%0d_nwords", t), got.size(), int'(tv[t].nw));
      for (int k = 0; k < int'(tv[t].nw) && k < got.size(); k++)
        chk($sformatf("v%0d_word%0d", t, k), got[k], int'(tv[t].w[8*k +: 8]));
      chk($sformatf("v%0d_ovf", t), int'(overflow), int'(tv[t].ovf));
      chk($sformatf("v%0d_odd", t), int'(odd_run), int'(tv[t].odd));
      chk($sformatf("v%0d_odd_n", t), int'(odd_run_n), 0);
    end
    do_reset(1'b0);
    run_str("110111101111110111111110", 1'b0);
    run_str("11", 1'b0);
    chk("full_valid", int'(len_valid), 1);
    cyc(1'b0, 1'b1);
    drain();
    chk("full_ovf", int'(overflow), 0);
    chk("full_nwords", got.size(), 5);
    if (got.size() == 5) begin
      chk("full_w0", got[0], 2);
      chk("full_w1", got[1], 4);
      chk("full_w2", got[2], 6);
      chk("full_w3", got[3], 8);
      chk("full_w4", got[4], 2);
    end
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("sat_valid", int'(len_valid_s), 1);
    chk("sat_len", int'(len_s), 15);
    chk("sat_odd", int'(odd_run_s), 1);
    chk("sat_main_len", int'(len), 20);
    drain();
    run_str("10", 1'b0);
    chk("mid_ovf_pre", int'(odd_run), 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    do_reset(1'b1);
    chk("mid_valid_s", int'(len_valid_s), 0);
    chk("mid_odd_s", int'(odd_run_s), 0);
    run_str("110", 1'b1);
    drain();
    chk("mid_nwords", got.size(), 1);
    if (got.size() == 1) chk("mid_w0", got[0], 2);
    chk("mid_odd", int'(odd_run), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
